// File: rtl/mac_pkg.sv
// Shared constants for the MAC datapath pipeline registers.
package mac_pkg;

    localparam int MAC_DATA_W     = 20;
    localparam int MAX_PIPE_DEPTH = 16;

    function automatic bit pipe_depth_ok(input int depth);
        return (depth >= 1) && (depth <= MAX_PIPE_DEPTH);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: data + valid flop, loads when adv is high.
module pipe_stage
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // Data only moves with a valid beat so empty slots do not toggle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (adv) begin
            valid_q <= v_in;
            if (v_in) begin
                data_q <= d_in;
            end
        end
    end

    assign d_out = data_q;
    assign v_out = valid_q;

endmodule

// File: rtl/reg_pipe.sv
// Elastic register pipeline with valid/ready backpressure, flush and occupancy count.
module reg_pipe
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_DATA_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    if (!pipe_depth_ok(DEPTH)) begin : g_bad_depth
        $error("reg_pipe: DEPTH out of range");
    end

    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A stage advances when any stage from it to the output is empty, or the output drains.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            adv[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!v[j]) begin
                    adv[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready  = adv[0] & ~flush & reset;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign out_xfer  = out_valid & out_ready;

    // Flush is applied as a forced advance of empty beats: valids clear, data holds.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] src_d;
        logic             src_v;

        if (g == 0) begin : g_first
            assign src_d = in_data;
            assign src_v = in_xfer;
        end else begin : g_rest
            assign src_d = d[g-1];
            assign src_v = v[g-1] & ~flush;
        end

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .reset (reset),
            .adv   (adv[g] | flush),
            .d_in  (src_d),
            .v_in  (src_v),
            .d_out (d[g]),
            .v_out (v[g])
        );
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CNT_W'(1);
        end else if (out_xfer && !in_xfer) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

    a_count_matches: assert property (@(posedge clk) disable iff (!reset)
        count_q == CNT_W'($countones(v)));
    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        int'(count_q) <= DEPTH);

endmodule

// File: tb/tb_reg_pipe.sv
// Scoreboard bench for reg_pipe: directed vectors on a 20x2 pipe, random sweeps on 32x1 and 8x5.
module tb_reg_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] a_in_data, a_out_data;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [1:0]  a_count;

    logic [31:0] b_in_data, b_out_data;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [0:0]  b_count;

    logic [7:0]  c_in_data, c_out_data;
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
    logic [2:0]  c_count;

    reg_pipe #(.WIDTH(20), .DEPTH(2)) u_a (
        .clk(clk), .reset(rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .flush(a_flush), .count(a_count));

    reg_pipe #(.WIDTH(32), .DEPTH(1)) u_b (
        .clk(clk), .reset(rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .flush(b_flush), .count(b_count));

    reg_pipe #(.WIDTH(8), .DEPTH(5)) u_c (
        .clk(clk), .reset(rst), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .flush(c_flush), .count(c_count));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: accepted beats are pushed with their accept cycle, popped on each output transfer.
    logic [31:0] qa_d[$], qb_d[$], qc_d[$];
    int          qa_t[$], qb_t[$], qc_t[$];
    int          stall_a = -1, stall_b = -1, stall_c = -1;

    always @(negedge clk) begin
        int t;
        logic [31:0] e;
        cyc++;
        if (!rst) begin
            qa_d.delete(); qa_t.delete();
            qb_d.delete(); qb_t.delete();
            qc_d.delete(); qc_t.delete();
        end else begin
            chk("a_count_vs_model", 32'(a_count), 32'(qa_d.size()));
            if (a_out_valid && a_out_ready) begin
                if (qa_d.size() == 0) chk("a_unexpected_out", 32'(a_out_valid), 32'd0);
                else begin
                    e = qa_d.pop_front(); t = qa_t.pop_front();
                    chk("a_out_data", 32'(a_out_data), e);
                    if (t > stall_a) chk("a_latency", 32'(cyc - t), 32'd2);
                end
            end
            if (a_in_valid && a_in_ready) begin qa_d.push_back(32'(a_in_data)); qa_t.push_back(cyc); end
            if (!a_out_ready) stall_a = cyc;
            if (a_flush) begin qa_d.delete(); qa_t.delete(); end

            chk("b_count_vs_model", 32'(b_count), 32'(qb_d.size()));
            if (b_out_valid && b_out_ready) begin
                if (qb_d.size() == 0) chk("b_unexpected_out", 32'(b_out_valid), 32'd0);
                else begin
                    e = qb_d.pop_front(); t = qb_t.pop_front();
                    chk("b_out_data", b_out_data, e);
                    if (t > stall_b) chk("b_latency", 32'(cyc - t), 32'd1);
                end
            end
            if (b_in_valid && b_in_ready) begin qb_d.push_back(b_in_data); qb_t.push_back(cyc); end
            if (!b_out_ready) stall_b = cyc;

            chk("c_count_vs_model", 32'(c_count), 32'(qc_d.size()));
            if (c_out_valid && c_out_ready) begin
                if (qc_d.size() == 0) chk("c_unexpected_out", 32'(c_out_valid), 32'd0);
                else begin
                    e = qc_d.pop_front(); t = qc_t.pop_front();
                    chk("c_out_data", 32'(c_out_data), e);
                    if (t > stall_c) chk("c_latency", 32'(cyc - t), 32'd5);
                end
            end
            if (c_in_valid && c_in_ready) begin qc_d.push_back(32'(c_in_data)); qc_t.push_back(cyc); end
            if (!c_out_ready) stall_c = cyc;
        end
    end

    task automatic tick(input logic iv, input logic [19:0] id, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        a_in_valid  = iv;
        a_in_data   = id;
        a_out_ready = ordy;
        a_flush     = fl;
        @(negedge clk);
    endtask

    initial begin
        a_in_valid = 1'b1; a_in_data = 20'h00005; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0; c_flush = 1'b0;

        // Reset held with input offered
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(a_out_valid), 32'd0);
        chk("reset_out_data", 32'(a_out_data), 32'd0);
        chk("reset_count", 32'(a_count), 32'd0);
        chk("reset_in_ready", 32'(a_in_ready), 32'd0);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(a_in_ready), 32'd1);
        chk("release_b_in_ready", 32'(b_in_ready), 32'd1);
        chk("release_c_in_ready", 32'(c_in_ready), 32'd1);

        // Streaming, unstalled
        tick(1'b1, 20'h00001, 1'b1, 1'b0); chk("st0_count", 32'(a_count), 32'd0);
        tick(1'b1, 20'h00002, 1'b1, 1'b0); chk("st1_out_valid", 32'(a_out_valid), 32'd0);
        tick(1'b1, 20'h00003, 1'b1, 1'b0); chk("st2_out_data", 32'(a_out_data), 32'h00001);
        chk("st2_count", 32'(a_count), 32'd2);
        tick(1'b0, 20'h0, 1'b1, 1'b0); chk("st3_out_data", 32'(a_out_data), 32'h00002);
        tick(1'b0, 20'h0, 1'b1, 1'b0); chk("st4_out_data", 32'(a_out_data), 32'h00003);
        chk("st4_count", 32'(a_count), 32'd1);
        tick(1'b0, 20'h0, 1'b1, 1'b0); chk("st5_out_valid", 32'(a_out_valid), 32'd0);
        chk("st5_count", 32'(a_count), 32'd0);

        // Backpressure
        tick(1'b1, 20'hABCDE, 1'b0, 1'b0); chk("bp0_in_ready", 32'(a_in_ready), 32'd1);
        tick(1'b1, 20'h12345, 1'b0, 1'b0); chk("bp1_bubble_ready", 32'(a_in_ready), 32'd1);
        chk("bp1_count", 32'(a_count), 32'd1);
        tick(1'b1, 20'h55555, 1'b0, 1'b0); chk("bp2_full_ready", 32'(a_in_ready), 32'd0);
        chk("bp2_count", 32'(a_count), 32'd2);
        chk("bp2_out_data", 32'(a_out_data), 32'hABCDE);
        tick(1'b1, 20'h55555, 1'b0, 1'b0); chk("bp3_hold_data", 32'(a_out_data), 32'hABCDE);
        chk("bp3_hold_ready", 32'(a_in_ready), 32'd0);
        tick(1'b1, 20'h55555, 1'b1, 1'b0); chk("bp4_passthru_ready", 32'(a_in_ready), 32'd1);
        chk("bp4_out_data", 32'(a_out_data), 32'hABCDE);
        tick(1'b0, 20'h0, 1'b0, 1'b0); chk("bp5_out_data", 32'(a_out_data), 32'h12345);
        chk("bp5_count", 32'(a_count), 32'd2);

        // Flush while full, input offered
        tick(1'b1, 20'h77777, 1'b0, 1'b1); chk("fl0_in_ready", 32'(a_in_ready), 32'd0);
        chk("fl0_out_valid", 32'(a_out_valid), 32'd1);
        tick(1'b0, 20'h0, 1'b0, 1'b0); chk("fl1_count", 32'(a_count), 32'd0);
        chk("fl1_out_valid", 32'(a_out_valid), 32'd0);
        chk("fl1_data_held", 32'(a_out_data), 32'h12345);

        // Flush together with an output transfer
        tick(1'b1, 20'h11111, 1'b1, 1'b0);
        tick(1'b1, 20'h22222, 1'b0, 1'b0);
        tick(1'b0, 20'h0, 1'b0, 1'b0); chk("fo0_count", 32'(a_count), 32'd2);
        tick(1'b0, 20'h0, 1'b1, 1'b1); chk("fo1_out_data", 32'(a_out_data), 32'h11111);
        tick(1'b0, 20'h0, 1'b0, 1'b0); chk("fo2_count", 32'(a_count), 32'd0);
        chk("fo2_out_valid", 32'(a_out_valid), 32'd0);

        // Asynchronous reset with two beats in flight
        tick(1'b1, 20'hAAAAA, 1'b1, 1'b0);
        tick(1'b1, 20'hBBBBB, 1'b0, 1'b0);
        tick(1'b0, 20'h0, 1'b0, 1'b0); chk("mr0_count", 32'(a_count), 32'd2);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("mr1_out_valid", 32'(a_out_valid), 32'd0);
        chk("mr1_count", 32'(a_count), 32'd0);
        chk("mr1_in_ready", 32'(a_in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 20'h0, 1'b1, 1'b0);
            chk("mr2_no_beat", 32'(a_out_valid), 32'd0);
        end

        // Random sweep on the 32x1 and 8x5 pipes; first stretch unstalled
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_in_data   = $urandom;
            b_out_ready = (n < 150) ? 1'b1 : ($urandom_range(0, 2) != 0);
            c_in_valid  = ($urandom_range(0, 3) != 0);
            c_in_data   = 8'($urandom);
            c_out_ready = (n < 150) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("b_drained", 32'(qb_d.size()), 32'd0);
        chk("c_drained", 32'(qc_d.size()), 32'd0);
        chk("b_end_count", 32'(b_count), 32'd0);
        chk("c_end_count", 32'(c_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_pipe.md
Name: reg_pipe

Overview:
- Parametrised elastic pipeline register. Successor to the fixed 20-bit bank of D flip-flops used in the MAC datapath.
- Generalised in WIDTH and DEPTH. Adds per-stage valid tracking, a valid/ready handshake with backpressure, a synchronous flush and an occupancy count.
- Sits between the multiplier, adder and accumulator stages of the MAC unit, so the controller can stall the datapath without losing operands.

Parameters:
- WIDTH, 20, data bits per stage.
- DEPTH, 2, number of register stages (legal 1..16).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  input  WIDTH  data offered by the upstream stage.
- in_valid  input  1  upstream has valid in_data.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  WIDTH  data of the last stage.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- flush  input  1  synchronous clear of all valid bits.
- count  output  CNT_W  number of stages currently holding valid data.

Behaviour:
- Storage: DEPTH stages s[0..DEPTH-1], each with WIDTH data bits and one valid bit. s[0] is nearest the input.
- Reset (reset=0, asynchronous): all valid bits go to 0 and all data goes to 0 immediately.
  - Outputs while in reset: out_valid=0, out_data=0, count=0, in_ready=0.
  - After reset deasserts, in_ready follows the normal rule from the same cycle.
- Advance rule (combinational):
  - adv[DEPTH-1] = !s[DEPTH-1].v | out_ready.
  - adv[i] = !s[i].v | adv[i+1].
  - in_ready = adv[0] & !flush & reset.
- Transfer: a beat transfers on a port when valid & ready are both high at the rising clk edge.
- Stage update at each clk edge, when flush=0 and stage i is advancing:
  - s[i] loads s[i-1]; s[0] loads in_data/in_valid.
  - The loaded valid is 0 if the source stage is empty or the input was not accepted.
  - Data of a stage whose loaded valid is 0 holds its old value (no toggle).
- A non-advancing stage holds both data and valid.
- Latency: an accepted beat appears at out_valid exactly DEPTH cycles after acceptance when no stall occurs.
- Throughput: 1 beat/cycle sustained with out_ready=1.
- Full: all valids set and out_ready=0. Then in_ready=0 and no stage changes.
- Full with out_ready=1: the whole pipe shifts, and in_ready=1 in the same cycle (pass-through ready, no bubble).
- Bubbles: interior bubbles collapse. An empty stage always accepts from upstream even if downstream is stalled.
- Flush=1 at a clk edge:
  - All valid bits cleared and count=0 next cycle. Data is unchanged.
  - The input is not accepted (in_ready=0 while flush=1).
  - out_valid still reflects the current state during the flush cycle. A downstream transfer in that cycle is legal and counts.
- Simultaneous flush and out_ready: the output transfer happens and the pipe is then empty.
- count is registered state:
  - Increments on an input transfer without an output transfer.
  - Decrements on an output transfer without an input transfer.
  - Unchanged when both or neither occur.
  - Set to 0 on flush.
  - Never exceeds DEPTH. A mismatch with the popcount of the valid bits is an assertion failure.
- Reset mid-operation: all in-flight data is discarded and no output transfer is generated afterward.
- DEPTH=1 degenerates to a single register with ready = !v | out_ready.

Decomposition:
- Shared package mac_pkg holds:
  - MAC_DATA_W = 20 (default WIDTH across MAC datapath instances).
  - MAX_PIPE_DEPTH = 16.
- One sub-module, pipe_stage: WIDTH data + valid flop with async active-low reset, ports clk, reset, adv, d_in, v_in, d_out, v_out.
- reg_pipe instantiates DEPTH copies in a generate loop and holds the ready chain and the count logic.

Test Plan:
- Reset/idle: hold reset=0 with in_valid=1 -> out_valid=0, count=0, in_ready=0. Release reset -> in_ready=1 the next cycle.
- Streaming, DEPTH=2: send 0x00001, 0x00002, 0x00003 on consecutive cycles with out_ready=1 -> out_data=0x00001 at cycle 2, then 0x00002 and 0x00003 back-to-back; count peaks at 2.
- Backpressure: fill with 0xABCDE and 0x12345, out_ready=0 -> in_ready=0, count=2, out_data holds 0xABCDE. Raise out_ready -> 0xABCDE transfers and in_ready=1 in the same cycle.
- Flush: with count=2, assert flush for 1 cycle with in_valid=1 -> input not accepted, count=0 and out_valid=0 the next cycle.
- Mid-stream reset: assert reset=0 asynchronously between edges with 2 beats in flight -> out_valid drops immediately and no beat emerges after release.
- Width/depth sweep: WIDTH=32 DEPTH=1 and WIDTH=8 DEPTH=5 with random valid/ready, compared against a reference FIFO model -> order preserved, no loss or duplication, latency = DEPTH when unstalled.
